// File: rtl/multi_decimate_pack_if.sv
// rtl/multi_decimate_pack_if.sv - sample/byte handshake bundle for multi_decimate_pack
interface multi_decimate_pack_if #(
    parameter int CHANNELS = 8,
    parameter int FACTOR_W = 8
);
    logic [CHANNELS-1:0]   sample_in;
    logic                  sample_valid;
    logic                  sample_ready;
    logic                  mode;
    logic [FACTOR_W-1:0]   factor;
    logic                  flush;
    logic [7*CHANNELS-1:0] byte_out;
    logic                  byte_valid;
    logic                  byte_ready;

    modport master (
        output sample_in, sample_valid, mode, factor, flush, byte_ready,
        input  sample_ready, byte_out, byte_valid
    );

    modport slave (
        input  sample_in, sample_valid, mode, factor, flush, byte_ready,
        output sample_ready, byte_out, byte_valid
    );
endinterface

// File: rtl/multi_decimate_pack.sv
// rtl/multi_decimate_pack.sv - multi-channel stretch/decimate packer into 7-pixel HIRES bytes
// Optional GLITCH_CAPTURE_EN: decimate windows report any toggle as an inverted pixel.
module multi_decimate_pack #(
    parameter int CHANNELS = 8,
    parameter int FACTOR_W = 8
) (
    input logic clk,
    input logic rst,
    multi_decimate_pack_if.slave bus
);
    localparam int BW = 7 * CHANNELS;

    logic [2:0]          bit_pos;
    logic [BW-1:0]       accum;
    logic [BW-1:0]       accum_w;
    logic [BW-1:0]       byte_q;
    logic                byte_valid_q;
    logic [FACTOR_W-1:0] pix_cnt;
    logic [FACTOR_W-1:0] dec_cnt;
    logic [FACTOR_W-1:0] fmax;
    logic                flush_pend;
    logic [CHANNELS-1:0] latch;
    logic [CHANNELS-1:0] keep_pix;
    logic                slot_ok, adv, ready_w, accept, emit, flush_exec, dec_keep;

    always_comb begin
        fmax       = (bus.factor == '0) ? FACTOR_W'(1) : bus.factor;
        slot_ok    = !byte_valid_q || bus.byte_ready;
        adv        = (pix_cnt != '0) && (bit_pos != 3'd6 || slot_ok);
        ready_w    = !rst && !flush_pend &&
                     (pix_cnt == '0 || (pix_cnt == FACTOR_W'(1) && adv));
        accept     = bus.sample_valid && ready_w;
        emit       = adv && (bit_pos == 3'd6);
        flush_exec = flush_pend && (pix_cnt == '0) && slot_ok;
        dec_keep   = (bus.factor <= FACTOR_W'(1)) || (dec_cnt == fmax - FACTOR_W'(1));
        accum_w    = accum;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < 7; b++) begin
                if (3'(b) == bit_pos) accum_w[7*c+b] = latch[c];
            end
        end
    end

`ifdef GLITCH_CAPTURE_EN
    logic [CHANNELS-1:0] last_pix;
    logic [CHANNELS-1:0] win_seen;
    logic [CHANNELS-1:0] win_now;

    always_comb begin
        win_now  = win_seen | (bus.sample_in ^ last_pix);
        keep_pix = (win_now & ~last_pix) | (~win_now & bus.sample_in);
    end

    always_ff @(posedge clk) begin
        if (rst || flush_exec) begin
            last_pix <= '0;
            win_seen <= '0;
        end else if (accept && bus.mode) begin
            if (dec_keep) begin
                last_pix <= keep_pix;
                win_seen <= '0;
            end else begin
                win_seen <= win_now;
            end
        end
    end
`else
    always_comb keep_pix = bus.sample_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_pos      <= '0;
            accum        <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            pix_cnt      <= '0;
            dec_cnt      <= '0;
            flush_pend   <= 1'b0;
            latch        <= '0;
        end else begin
            flush_pend <= bus.flush || (flush_pend && !flush_exec);

            if (emit || (flush_exec && bit_pos != 3'd0)) begin
                byte_q       <= emit ? accum_w : accum;
                byte_valid_q <= 1'b1;
            end else if (bus.byte_ready) begin
                byte_valid_q <= 1'b0;
            end

            if (adv) begin
                pix_cnt <= pix_cnt - FACTOR_W'(1);
                if (bit_pos == 3'd6) begin
                    accum   <= '0;
                    bit_pos <= '0;
                end else begin
                    accum   <= accum_w;
                    bit_pos <= bit_pos + 3'd1;
                end
            end

            if (flush_exec) begin
                accum   <= '0;
                bit_pos <= '0;
                dec_cnt <= '0;
            end

            // Accept overrides the adv decrement: it only fires once pix_cnt reaches 0.
            if (accept) begin
                if (!bus.mode) begin
                    latch   <= bus.sample_in;
                    pix_cnt <= fmax;
                    dec_cnt <= '0;
                end else if (dec_keep) begin
                    latch   <= keep_pix;
                    pix_cnt <= FACTOR_W'(1);
                    dec_cnt <= '0;
                end else begin
                    dec_cnt <= dec_cnt + FACTOR_W'(1);
                end
            end
        end
    end

    assign bus.sample_ready = ready_w;
    assign bus.byte_out     = byte_q;
    assign bus.byte_valid   = byte_valid_q;
endmodule

// File: tb/tb_multi_decimate_pack.sv
// tb/tb_multi_decimate_pack.sv - directed self-checking bench for multi_decimate_pack
module tb_multi_decimate_pack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   first_acc = 0;
    logic [55:0] got[$];

`ifdef GLITCH_CAPTURE_EN
    localparam logic [55:0] EXP_GLITCH = 56'h200000;
`else
    localparam logic [55:0] EXP_GLITCH = 56'h0;
`endif

    multi_decimate_pack_if #(.CHANNELS(8), .FACTOR_W(8)) bus ();

    multi_decimate_pack #(.CHANNELS(8), .FACTOR_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && bus.byte_valid && bus.byte_ready) got.push_back(bus.byte_out);
    end

    task automatic check(input string tag, input logic [55:0] obs, input logic [55:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] s);
        int n = 0;
        bit ok = 1'b0;
        bus.sample_in    = s;
        bus.sample_valid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (bus.sample_ready) ok = 1'b1;
            n++;
        end
        @(posedge clk);
        #1;
        last_acc         = cyc;
        bus.sample_valid = 1'b0;
        if (!ok) check("send_accepted", 56'(ok), 56'd1);
    endtask

    task automatic expect_byte(input string tag, input logic [55:0] exp);
        int n = 0;
        while (got.size() == 0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({tag, "_present"}, 56'(got.size() != 0), 56'd1);
        if (got.size() != 0) check(tag, got.pop_front(), exp);
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    initial begin
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.mode         = 1'b0;
        bus.factor       = 8'd3;
        bus.flush        = 1'b0;
        bus.byte_ready   = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_byte_valid", 56'(bus.byte_valid), 56'd0);
        check("rst_byte_out", bus.byte_out, 56'h0);
        check("rst_sample_ready", 56'(bus.sample_ready), 56'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 56'(bus.sample_ready), 56'd1);

        // Test 1: stretch x3, FF 00 FF -> 1000111 then partial 0000011 on flush
        send(8'hFF);
        send(8'h00);
        send(8'hFF);
        expect_byte("t1_byte", {8{7'h47}});
        repeat (4) tick();
        pulse_flush();
        expect_byte("t1_flush", {8{7'h03}});
        repeat (4) tick();
        check("t1_no_extra", 56'(got.size()), 56'd0);

        // Test 2: factor 0 behaves as 1, one accept per cycle
        bus.factor = 8'd0;
        send(8'hFF);
        first_acc = last_acc;
        repeat (6) send(8'hFF);
        check("t2_cadence", 56'(last_acc - first_acc), 56'd6);
        expect_byte("t2_byte", {8{7'h7F}});

        // Test 3: decimate x4, ch0 = idx[2], kept idx 3,7,..,27 -> 0101010
        bus.mode   = 1'b1;
        bus.factor = 8'd4;
        for (int i = 0; i < 28; i++) send({7'b0, i[2]});
        expect_byte("t3_byte", 56'h2A);

        // Test 4: backpressure at byte completion
        bus.mode       = 1'b0;
        bus.factor     = 8'd1;
        bus.byte_ready = 1'b0;
        repeat (7) send(8'h0F);
        repeat (7) send(8'hF0);
        bus.sample_in    = 8'h01;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_valid", 56'(bus.byte_valid), 56'd1);
            check("t4_hold_out", bus.byte_out, 56'h00000000FFFFFFF);
            check("t4_ready_low", 56'(bus.sample_ready), 56'd0);
        end
        check("t4_no_handshake", 56'(got.size()), 56'd0);
        bus.byte_ready = 1'b1;
        send(8'h01);
        expect_byte("t4_first", 56'h00000000FFFFFFF);
        expect_byte("t4_second", 56'hFFFFFFF0000000);
        repeat (3) tick();
        check("t4_no_dup", 56'(got.size()), 56'd0);
        pulse_flush();
        expect_byte("t4_tail", 56'h1);

        // Test 5: decimate x8, one-sample pulse on ch3 at dropped sample 2
        bus.mode   = 1'b1;
        bus.factor = 8'd8;
        for (int i = 0; i < 8; i++) send((i == 2) ? 8'h08 : 8'h00);
        repeat (2) tick();
        pulse_flush();
        expect_byte("t5_glitch", EXP_GLITCH);

        // Test 6: reset mid-byte with a held output byte
        bus.mode       = 1'b0;
        bus.factor     = 8'd1;
        bus.byte_ready = 1'b0;
        repeat (7) send(8'hFF);
        repeat (4) send(8'h00);
        tick();
        check("t6_pre_valid", 56'(bus.byte_valid), 56'd1);
        rst = 1'b1;
        tick();
        check("t6_rst_valid", 56'(bus.byte_valid), 56'd0);
        check("t6_rst_out", bus.byte_out, 56'h0);
        check("t6_rst_ready", 56'(bus.sample_ready), 56'd0);
        rst = 1'b0;
        #1;
        check("t6_ready_after", 56'(bus.sample_ready), 56'd1);
        check("t6_nothing_sent", 56'(got.size()), 56'd0);
        bus.byte_ready = 1'b1;
        repeat (7) send(8'h55);
        expect_byte("t6_fresh", {7'h00, 7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
